axis_pkt_fifo: RTL
==================

Name: axis_pkt_fifo

Overview:
- AXI-Stream buffer that sits directly downstream of the 2:1 AXI-Stream mux.
- Consumes the mux output stream (DATA_out/TVALID_out/TLAST_out) and returns backpressure through the mux's TREADY_out input.
- Buffers up to DEPTH beats and presents them to the next consumer.
- In packet mode it holds off output until a complete TLAST-terminated packet is stored, so downstream never sees a stalled partial packet.

Parameters:
- DATA_WIDTH, 8, width of the data bus.
- DEPTH, 16, number of storage entries; must be a power of 2 and at least 2.
- PKT_MODE, 1, 1 = release only complete packets; 0 = plain first-word-fall-through FIFO.

Ports:
- ACLK  input  1  clock; all state updates on the rising edge.
- ARESETn  input  1  asynchronous, active-low reset.
- DATA_in  input  DATA_WIDTH  slave data, driven by the mux DATA_out.
- TVALID_in  input  1  slave valid.
- TLAST_in  input  1  slave last-beat marker.
- TREADY_in  output  1  slave ready; drives the mux TREADY_out.
- DATA_out  output  DATA_WIDTH  master data.
- TVALID_out  output  1  master valid.
- TLAST_out  output  1  master last-beat marker.
- TREADY_out  input  1  master ready from the downstream consumer.
- fill_level  output  $clog2(DEPTH)+1  number of beats stored.
- pkt_count  output  $clog2(DEPTH)+1  number of complete packets stored.
- full  output  1  fill_level == DEPTH.
- empty  output  1  fill_level == 0.
- pkt_overrun  output  1  sticky flag: a packet exceeded the buffer in packet mode.

Behaviour:
- Reset: ARESETn low asynchronously clears the following: write/read pointers, fill_level, pkt_count, pkt_overrun, rdy_q and force_rel.
  - While reset is asserted: TVALID_out=0, TREADY_in=0, full=0, empty=1.
- Ready generation:
  - rdy_q is set to 1 on the first ACLK edge after reset release.
  - TREADY_in = rdy_q & ~full.
- Storage: DEPTH x (DATA_WIDTH+1) array holding {TLAST, data}. Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- Write: when TVALID_in & TREADY_in, store {TLAST_in, DATA_in} at wr_ptr and increment wr_ptr.
- Read: when TVALID_out & TREADY_out, increment rd_ptr.
  - DATA_out and TLAST_out come combinationally from mem[rd_ptr] (first-word fall-through).
  - DATA_out and TLAST_out are don't-care while TVALID_out=0.
- Latency: a beat accepted at edge N can appear on the output after edge N, i.e. one cycle later, subject to the packet-mode gate.
- fill_level:
  - +1 on write only; -1 on read only.
  - Unchanged on simultaneous write and read, or when neither occurs.
- pkt_count:
  - +1 on a write with TLAST_in=1; -1 on a read with TLAST_out=1.
  - Unchanged when both occur in the same cycle.
- TVALID_out:
  - PKT_MODE=0: TVALID_out = ~empty.
  - PKT_MODE=1: TVALID_out = ~empty & (pkt_count != 0 | force_rel).
- Overrun release (PKT_MODE=1 only):
  - Trigger: full=1 and pkt_count=0.
  - Action: force_rel and pkt_overrun set at the next edge.
  - force_rel clears on the edge where a beat with TLAST_out=1 is read; pkt_overrun stays set until reset.
  - Purpose: a packet longer than DEPTH drains instead of deadlocking.
- Boundaries:
  - Full: no write accepted; a read in the same cycle frees a slot for the next cycle only, with no combinational ready-through.
  - Empty: no read is possible; a write and TVALID_out=0 give no read.
  - Data and TLAST must be held stable on the master side while TVALID_out=1 and TREADY_out=0.
- Reset mid-packet: all buffered beats are discarded; after reset the block behaves as after power-up.

Decomposition:
- Shared package axis_pkg holds:
  - localparam function clog2-based width helper.
  - typedef axis_beat_t {logic last; logic [DATA_WIDTH-1:0] data}.
- Natural sub-module: axis_fifo_mem, the simple dual-port array with registered write and asynchronous read.
- Pointers, counters and the release logic stay in the top module.

Test Plan:
- Reset release, PKT_MODE=0, DEPTH=16: write 0x11, 0x22, 0x33 on consecutive cycles with TREADY_out=1 -> TVALID_out first high the cycle after 0x11 is accepted; output order 0x11, 0x22, 0x33; fill_level never exceeds 1.
- Fill, PKT_MODE=0: TREADY_out=0, write 16 beats -> full=1, TREADY_in=0 after the 16th; a 17th beat is not accepted. Then TREADY_out=1 for one cycle -> fill_level=15, TREADY_in=1 on the next cycle.
- Packet gate, PKT_MODE=1: write 7 beats with TLAST=0 -> TVALID_out=0. Write an 8th beat 0x08 with TLAST=1 -> pkt_count=1, TVALID_out=1. Drain all 8 beats -> TLAST_out=1 only on 0x08; pkt_count=0.
- Simultaneous events: pkt_count=1; in the same cycle write a TLAST beat and read a TLAST beat -> pkt_count stays 1; fill_level unchanged.
- Overrun, PKT_MODE=1, DEPTH=16: send a 20-beat packet -> at full with pkt_count=0, pkt_overrun=1 and TVALID_out=1. All 20 beats delivered in order; force_rel clears after the TLAST read; pkt_overrun remains 1.
- Mid-packet reset: 5 beats buffered, pulse ARESETn low between clock edges -> immediately TVALID_out=0, TREADY_in=0, fill_level=0. After release, TREADY_in=1 from the first edge.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet FIFO slice.
//   ptr_width()  - address width for a storage array of a given depth
//   axis_beat_t  - stored beat layout {last, data} at the default bus width;
//                  modules with other widths keep the same {last, data} order
package axis_pkg;

  localparam int AXIS_DEFAULT_DW = 8;

  // Address width for a power-of-2 depth (depth >= 2).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic                       last;
    logic [AXIS_DEFAULT_DW-1:0] data;
  } axis_beat_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// Simple dual-port storage array: registered write, asynchronous read.
// Ports:
//   clk_i      - write clock
//   wr_en_i    - write strobe
//   wr_addr_i  - write address
//   wr_data_i  - write data
//   rd_addr_i  - read address
//   rd_data_o  - read data (combinational from rd_addr_i)
module axis_fifo_mem
  import axis_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is not reset: validity is tracked entirely by the pointers.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream buffer placed downstream of the 2:1 mux. First-word fall-through
// FIFO; in packet mode the output is held until a full TLAST-terminated
// packet is stored, unless a single packet overflows the buffer, in which
// case it is released early (force_rel) and pkt_overrun latches.
// Handshake: a beat moves on a port only in a cycle where valid and ready are
// both high at the rising edge; valid never waits on ready, and the master
// side holds DATA_out/TLAST_out stable while TVALID_out=1 and TREADY_out=0.
// Ports:
//   ACLK, ARESETn                       - clock, async active-low reset
//   DATA_in/TVALID_in/TLAST_in/TREADY_in - slave side (from the mux)
//   DATA_out/TVALID_out/TLAST_out/TREADY_out - master side
//   fill_level, pkt_count               - stored beats / complete packets
//   full, empty, pkt_overrun            - status
module axis_pkt_fifo
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int PKT_MODE   = 1
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [DATA_WIDTH-1:0]      DATA_in,
  input  logic                       TVALID_in,
  input  logic                       TLAST_in,
  output logic                       TREADY_in,
  output logic [DATA_WIDTH-1:0]      DATA_out,
  output logic                       TVALID_out,
  output logic                       TLAST_out,
  input  logic                       TREADY_out,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [$clog2(DEPTH):0]     pkt_count,
  output logic                       full,
  output logic                       empty,
  output logic                       pkt_overrun
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Same {last, data} layout as axis_beat_t, sized to this instance.
  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic             rdy_q;
  logic             force_rel_q, force_rel_d;
  logic             overrun_q, overrun_d;

  beat_t wr_beat, rd_beat;
  logic  wr_en, rd_en;

  assign wr_beat = '{last: TLAST_in, data: DATA_in};

  axis_fifo_mem #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk_i     (ACLK),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_beat),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_beat)
  );

  assign full       = (fill_q == DEPTH_C);
  assign empty      = (fill_q == '0);
  // Ready depends only on registered state, never on TREADY_out.
  assign TREADY_in  = rdy_q & ~full;
  assign TVALID_out = ~empty & ((PKT_MODE == 0) | (pkt_q != '0) | force_rel_q);
  assign DATA_out   = rd_beat.data;
  assign TLAST_out  = rd_beat.last;
  assign fill_level = fill_q;
  assign pkt_count  = pkt_q;
  assign pkt_overrun = overrun_q;

  assign wr_en = TVALID_in & TREADY_in;
  assign rd_en = TVALID_out & TREADY_out;

  always_comb begin
    // Power-of-2 depth: pointers wrap by natural overflow.
    wr_ptr_d    = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d    = rd_ptr_q + PTR_W'(rd_en);
    fill_d      = fill_q;
    pkt_d       = pkt_q;
    force_rel_d = force_rel_q;
    overrun_d   = overrun_q;

    case ({wr_en, rd_en})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase

    case ({wr_en & TLAST_in, rd_en & rd_beat.last})
      2'b10:   pkt_d = pkt_q + 1'b1;
      2'b01:   pkt_d = pkt_q - 1'b1;
      default: pkt_d = pkt_q;
    endcase

    if (PKT_MODE != 0) begin
      if (rd_en && rd_beat.last) begin
        force_rel_d = 1'b0;
      end
      // Buffer full with no terminated packet: the packet is larger than the
      // buffer, so drain it rather than deadlock. No stored TLAST exists in
      // this state, so the clear above cannot coincide with it.
      if (full && (pkt_q == '0)) begin
        force_rel_d = 1'b1;
        overrun_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      pkt_q       <= '0;
      rdy_q       <= 1'b0;
      force_rel_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      pkt_q       <= pkt_d;
      rdy_q       <= 1'b1;
      force_rel_q <= force_rel_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule
